fifo_rr_arbiter: RTL and testbench

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter.sv | 93 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: four-requester round-robin arbiter feeding a single-entry
// registered slot. Grants are combinational; the slot, tag and rotating
// priority pointer are registered. Synchronous active-low reset.
module fifo_rr_arbiter #(
  parameter int width = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [3:0]           REQ,
  input  logic [4*width-1:0]   D_IN,
  output logic [3:0]           GNT,
  output logic [width-1:0]     D_OUT,
  output logic [1:0]           TAG_OUT,
  output logic                 EMPTY_N,
  input  logic                 DEQ,
  input  logic                 CLR
);

  logic             full;
  logic [width-1:0] data;
  logic [1:0]       tag;
  logic [1:0]       ptr;

  logic             can_accept;
  logic             grant;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic [width-1:0] sel_data;

  // Slot can take a new entry when empty or when the held entry leaves this cycle.
  assign can_accept = !full || DEQ;
  assign grant      = can_accept && (|REQ) && !CLR && RST;

  // Rotating-priority search: first set request at ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Payload slice of the winning requester.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (win == 2'(i)) sel_data = D_IN[i*width +: width];
    end
  end

  // One-hot grant, zero-cycle latency.
  always_comb begin
    GNT = '0;
    if (grant) GNT[win] = 1'b1;
  end

  // Slot and pointer update: reset > CLR > grant > DEQ.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      full <= 1'b0;
      data <= '0;
      tag  <= '0;
      ptr  <= '0;
    end else if (CLR) begin
      full <= 1'b0;
    end else if (grant) begin
      full <= 1'b1;
      data <= sel_data;
      tag  <= win;
      ptr  <= win + 2'd1;
    end else if (DEQ) begin
      full <= 1'b0;
    end
  end

  // Simulation warning for a dequeue issued against an empty slot.
  always_ff @(posedge CLK) begin
    if (RST && DEQ && !full) begin
      $warning("fifo_rr_arbiter: %m -- Dequeuing from empty fifo");
    end
  end

  assign EMPTY_N = full;
  assign D_OUT   = data;
  assign TAG_OUT = tag;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed testbench for fifo_rr_arbiter with a scoreboard of expected slot
// contents, pushed when a grant is expected and popped after the load edge.
module tb_fifo_rr_arbiter;

  localparam int W = 8;

  logic           CLK;
  logic           RST;
  logic [3:0]     REQ;
  logic [4*W-1:0] D_IN;
  logic [3:0]     GNT;
  logic [W-1:0]   D_OUT;
  logic [1:0]     TAG_OUT;
  logic           EMPTY_N;
  logic           DEQ;
  logic           CLR;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   tag;
    logic [W-1:0] data;
  } entry_t;

  entry_t sb[$];

  fifo_rr_arbiter #(.width(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .D_IN    (D_IN),
    .GNT     (GNT),
    .D_OUT   (D_OUT),
    .TAG_OUT (TAG_OUT),
    .EMPTY_N (EMPTY_N),
    .DEQ     (DEQ),
    .CLR     (CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect a grant to requester w and record what the slot should then hold.
  task automatic expect_grant(input string tag, input logic [1:0] w);
    entry_t e;
    chk(tag, 32'(GNT), 32'(4'b0001 << w));
    e.tag  = w;
    e.data = D_IN[w*W +: W];
    sb.push_back(e);
  endtask

  // Compare the slot against the oldest expected entry.
  task automatic pop_check(input string tag);
    entry_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_full"}, 32'(EMPTY_N), 32'(1'b1));
      chk({tag, "_tag"},  32'(TAG_OUT), 32'(e.tag));
      chk({tag, "_data"}, 32'(D_OUT),   32'(e.data));
    end
  endtask

  initial begin
    RST  = 1'b0;
    REQ  = 4'b1111;
    D_IN = {8'h44, 8'h33, 8'h22, 8'h11};
    DEQ  = 1'b0;
    CLR  = 1'b0;

    // Reset held for two cycles with all requests active.
    tick();
    tick();
    settle();
    chk("rst_gnt",   32'(GNT),     32'(4'b0000));
    chk("rst_empty", 32'(EMPTY_N), 32'(1'b0));
    chk("rst_tag",   32'(TAG_OUT), 32'(2'd0));
    chk("rst_data",  32'(D_OUT),   32'(8'h00));

    // Release: first cycle grants requester 0, then slot is full and blocks.
    RST = 1'b1;
    settle();
    expect_grant("rel_gnt", 2'd0);
    tick();
    settle();
    chk("rel_gnt_blocked", 32'(GNT), 32'(4'b0000));
    pop_check("rel_fill");

    // Round-robin with continuous dequeue: tags 1,2,3,0 follow the first 0.
    DEQ = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      expect_grant($sformatf("rr_gnt%0d", k), 2'(k % 4));
      tick();
      pop_check($sformatf("rr_out%0d", k));
    end

    // Move pointer to 2 via a lone grant to requester 1.
    REQ = 4'b0010;
    settle();
    expect_grant("prep_gnt", 2'd1);
    tick();
    pop_check("prep_out");

    // Skipping: ptr=2, REQ=0011 wraps to requester 0, then requester 1.
    REQ = 4'b0011;
    settle();
    expect_grant("skip_gnt0", 2'd0);
    tick();
    pop_check("skip_out0");
    settle();
    expect_grant("skip_gnt1", 2'd1);
    tick();
    pop_check("skip_out1");

    // Full without dequeue: no grant, slot contents held.
    DEQ = 1'b0;
    REQ = 4'b0100;
    D_IN[2*W +: W] = 8'h5A;
    settle();
    chk("full_nogrant", 32'(GNT), 32'(4'b0000));
    tick();
    chk("full_hold_tag",  32'(TAG_OUT), 32'(2'd1));
    chk("full_hold_data", 32'(D_OUT),   32'(8'h22));
    chk("full_hold_flag", 32'(EMPTY_N), 32'(1'b1));
    // Dequeue opens the slot in the same cycle (pass-through replace).
    DEQ = 1'b1;
    settle();
    expect_grant("pass_gnt", 2'd2);
    tick();
    pop_check("pass_out");

    // Clear: no grant, slot empties, pointer (now 3) and data untouched.
    CLR = 1'b1;
    REQ = 4'b1000;
    settle();
    chk("clr_gnt", 32'(GNT), 32'(4'b0000));
    tick();
    chk("clr_empty", 32'(EMPTY_N), 32'(1'b0));
    chk("clr_tag",   32'(TAG_OUT), 32'(2'd2));
    chk("clr_data",  32'(D_OUT),   32'(8'h5A));
    CLR = 1'b0;
    DEQ = 1'b0;
    REQ = 4'b1111;
    settle();
    expect_grant("clr_ptr_gnt", 2'd3);
    tick();
    pop_check("clr_ptr_out");

    // Normal dequeue empties the slot, then a dequeue on an empty slot.
    REQ = 4'b0000;
    DEQ = 1'b1;
    settle();
    chk("deq_gnt", 32'(GNT), 32'(4'b0000));
    tick();
    chk("deq_empty", 32'(EMPTY_N), 32'(1'b0));
    tick();
    chk("deq_mt_empty", 32'(EMPTY_N), 32'(1'b0));
    chk("deq_mt_tag",   32'(TAG_OUT), 32'(2'd3));
    chk("deq_mt_data",  32'(D_OUT),   32'(8'h44));
    // Pointer still 0 after the idle cycles.
    DEQ = 1'b0;
    REQ = 4'b1111;
    settle();
    expect_grant("deq_ptr_gnt", 2'd0);
    tick();
    pop_check("deq_ptr_out");

    // Reset mid-operation discards the held entry.
    RST = 1'b0;
    settle();
    chk("mid_rst_gnt", 32'(GNT), 32'(4'b0000));
    tick();
    chk("mid_rst_empty", 32'(EMPTY_N), 32'(1'b0));
    chk("mid_rst_data",  32'(D_OUT),   32'(8'h00));
    chk("mid_rst_tag",   32'(TAG_OUT), 32'(2'd0));
    RST = 1'b1;
    REQ = 4'b0100;
    settle();
    expect_grant("post_rst_gnt", 2'd2);
    tick();
    pop_check("post_rst_out");

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
